// File: rtl/fp_div_seq.sv
// fp_div_seq: IEEE-754 single-precision divider, restoring division at one quotient bit per cycle.
// Latency: out_valid 28 cycles after acceptance for finite nonzero operands, 2 cycles for special operands.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_div_seq #(
    parameter string round = "away_zero"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] z,
    output logic [7:0]  status,
    output logic        out_valid,
    input  logic        out_ready
);

    // Rounding modes. "away_zero" is directed rounding away from zero:
    // any nonzero guard or sticky bumps the magnitude.
    localparam logic [1:0] RM_AWAY = 2'd0;
    localparam logic [1:0] RM_ZERO = 2'd1;
    localparam logic [1:0] RM_NEAR = 2'd2;
    localparam logic [1:0] RMODE   = (round == "IEEE_near") ? RM_NEAR :
                                     (round == "to_zero")   ? RM_ZERO : RM_AWAY;

    // status bit positions; bit 7 is always 0
    localparam int ST_ZERO = 0;
    localparam int ST_INF  = 1;
    localparam int ST_NAN  = 2;
    localparam int ST_TINY = 3;
    localparam int ST_HUGE = 4;
    localparam int ST_INX  = 5;
    localparam int ST_DZ   = 6;

    localparam logic [4:0] LAST_STEP = 5'd25;

    typedef enum logic [2:0] {IDLE, SPECIAL, DIVIDE, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] z_q, z_d;
    logic [7:0]  status_q, status_d;

    // operand classification (denormals count as zero)
    logic sign;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic acc_special;
    logic [31:0] spec_z;
    logic [7:0]  spec_st;

    // division step
    logic [24:0] mb;
    logic        ge;
    logic [24:0] diff;

    // rounding / packing
    logic               lead, guard, sticky, rup, carry;
    logic [23:0]        mant24;
    logic [24:0]        mant25;
    logic [22:0]        frac;
    logic signed [9:0]  e_raw, e_fin;
    logic [31:0]        rnd_z;
    logic [7:0]         rnd_st;

    // Special-operand resolution, in priority order: NaN, x/0, inf/x, zero result.
    always_comb begin
        sign    = a_q[31] ^ b_q[31];
        a_zero  = (a_q[30:23] == 8'h00);
        b_zero  = (b_q[30:23] == 8'h00);
        a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        acc_special = (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
                      (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
        spec_z  = '0;
        spec_st = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_z          = 32'h7FC0_0000;
            spec_st[ST_NAN] = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_z          = {sign, 8'hFF, 23'd0};
            spec_st[ST_INF] = 1'b1;
            spec_st[ST_DZ]  = 1'b1;
        end else if (a_inf) begin
            spec_z          = {sign, 8'hFF, 23'd0};
            spec_st[ST_INF] = 1'b1;
        end else begin
            spec_z           = {sign, 31'd0};
            spec_st[ST_ZERO] = 1'b1;
        end
    end

    // One restoring-division step: subtract divisor if it fits, then shift remainder.
    always_comb begin
        mb   = {2'b01, b_q[22:0]};
        ge   = (rem_q >= mb);
        diff = ge ? (rem_q - mb) : rem_q;
    end

    // Normalize the 26-bit quotient, round, and pack with overflow/underflow handling.
    always_comb begin
        lead   = quo_q[25];
        mant24 = lead ? quo_q[25:2] : quo_q[24:1];
        guard  = lead ? quo_q[1] : quo_q[0];
        sticky = (lead & quo_q[0]) | (|rem_q);
        if (RMODE == RM_NEAR) begin
            rup = guard & (sticky | mant24[0]);
        end else if (RMODE == RM_ZERO) begin
            rup = 1'b0;
        end else begin
            rup = guard | sticky;
        end
        mant25 = {1'b0, mant24} + {24'd0, rup};
        carry  = mant25[24];
        frac   = carry ? mant25[23:1] : mant25[22:0];
        e_raw  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
               + 10'sd127 - $signed({9'd0, ~lead});
        e_fin  = e_raw + $signed({9'd0, carry});
        rnd_st = '0;
        if (e_fin >= 10'sd255) begin
            rnd_z           = {sign, 8'hFF, 23'd0};
            rnd_st[ST_HUGE] = 1'b1;
            rnd_st[ST_INF]  = 1'b1;
            rnd_st[ST_INX]  = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            rnd_z           = {sign, 31'd0};
            rnd_st[ST_TINY] = 1'b1;
            rnd_st[ST_ZERO] = 1'b1;
            rnd_st[ST_INX]  = 1'b1;
        end else begin
            rnd_z          = {sign, e_fin[7:0], frac};
            rnd_st[ST_INX] = guard | sticky;
        end
    end

    // FSM next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        status_d  = status_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    rem_d   = {2'b01, a[22:0]};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = acc_special ? SPECIAL : DIVIDE;
                end
            end
            SPECIAL: begin
                z_d      = spec_z;
                status_d = spec_st;
                state_d  = DONE;
            end
            DIVIDE: begin
                rem_d = diff << 1;
                quo_d = {quo_q[24:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                z_d      = rnd_z;
                status_d = rnd_st;
                state_d  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            status_q <= status_d;
        end
    end

    assign z      = z_q;
    assign status = status_q;

endmodule
